// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point add/sub unit.
// Format is {sign, biased exponent, fraction} with a hidden leading one.
package fp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   localparam int ST_ZERO = 0;
   localparam int ST_OVF  = 1;
   localparam int ST_UNF  = 2;
   localparam int ST_INX  = 3;

   // Wide enough for any practical format; callers slice what they need.
   typedef struct packed {
      logic        sign;
      logic [15:0] exp;
      logic [63:0] frac;
   } fp_fields_t;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_width(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int fp_exp_max(input int exp_w);
      return (1 << exp_w) - 1;
   endfunction

   function automatic fp_fields_t fp_unpack(input logic [63:0] word, input int exp_w,
                                            input int man_w);
      fp_fields_t f;
      logic [63:0] s;
      f.frac = word & ((64'd1 << man_w) - 64'd1);
      s      = word >> man_w;
      f.exp  = 16'(s & ((64'd1 << exp_w) - 64'd1));
      s      = s >> exp_w;
      f.sign = s[0];
      return f;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even on a normalised mantissa with G/R/S bits, then
// saturate or flush on exponent range and pack the result word.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int EXP_W = 6,
   parameter int MAN_W = 25
) (
   input  logic                     sign,
   input  logic signed [EXP_W+1:0]  exp_in,
   input  logic [MAN_W:0]           mant,
   input  logic [2:0]               grs,
   output logic [EXP_W+MAN_W:0]     result,
   output logic [3:0]               status
);
   localparam logic signed [EXP_W+1:0] E_ONE  = (EXP_W+2)'(1);
   localparam logic signed [EXP_W+1:0] E_ZERO = '0;
   localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'(fp_exp_max(EXP_W));

   logic                    round_up;
   logic [MAN_W+1:0]        sum;
   logic signed [EXP_W+1:0] exp_r;
   logic [MAN_W-1:0]        frac_r;

   always_comb begin
      round_up = grs[2] & (grs[1] | grs[0] | mant[0]);
      sum      = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
      if (sum[MAN_W+1]) begin
         exp_r  = exp_in + E_ONE;
         frac_r = sum[MAN_W:1];
      end else begin
         exp_r  = exp_in;
         frac_r = sum[MAN_W-1:0];
      end
      status         = '0;
      status[ST_INX] = |grs;
      result         = {sign, exp_r[EXP_W-1:0], frac_r};
      if (exp_r >= E_MAX) begin
         result          = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         status[ST_OVF]  = 1'b1;
         status[ST_INX]  = 1'b1;
      end else if (exp_r <= E_ZERO) begin
         result          = {sign, {(EXP_W+MAN_W){1'b0}}};
         status[ST_UNF]  = 1'b1;
         status[ST_INX]  = 1'b1;
         status[ST_ZERO] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_addsub_param.sv
// Multi-cycle floating-point adder/subtractor with start/busy/done handshake.
// One operation in flight; alignment and normalisation shift one bit per cycle.
module fp_addsub_param
   import fp_pkg::*;
#(
   parameter int EXP_W = 6,
   parameter int MAN_W = 25
) (
   input  logic                 clock_100kHz,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 op_sub,
   input  logic [EXP_W+MAN_W:0] Op_A_in,
   input  logic [EXP_W+MAN_W:0] Op_B_in,
   output logic                 busy,
   output logic                 done,
   output logic [EXP_W+MAN_W:0] data_out,
   output logic [3:0]           status_out
);
   localparam int W    = fp_width(EXP_W, MAN_W);
   localparam int KMAX = MAN_W + 3;
   localparam int CW   = $clog2(KMAX + 1);
   localparam logic signed [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);

   state_t                  state_reg, state_next;
   logic [W-1:0]            a_reg, a_next, b_reg, b_next;
   logic                    sub_reg, sub_next;
   logic                    sign_reg, sign_next, eff_sub_reg, eff_sub_next;
   logic signed [EXP_W+1:0] exp_reg, exp_next;
   logic [MAN_W:0]          x_reg, x_next;
   logic [MAN_W+3:0]        y_reg, y_next;
   logic [MAN_W+4:0]        w_reg, w_next;
   logic [CW-1:0]           cnt_reg, cnt_next;
   logic                    bypass_reg, bypass_next;
   logic [W-1:0]            res_data_reg, res_data_next, data_reg, data_next;
   logic [3:0]              res_status_reg, res_status_next, status_reg, status_next;

   fp_fields_t              fa, fb;
   logic                    unused_fields;
   logic [EXP_W-1:0]        ea, eb, ex, ey;
   logic [MAN_W-1:0]        fra, frb, frx, fry;
   logic [EXP_W+MAN_W-1:0]  mag_a, mag_b;
   logic                    sa, sb_eff, sx, sy, sat_a, sat_b, swap;
   int                      k_align;
   logic [MAN_W+4:0]        x_ext, y_ext, sum;
   logic [W-1:0]            rp_result;
   logic [3:0]              rp_status;

   assign fa = fp_unpack(64'(a_reg), EXP_W, MAN_W);
   assign fb = fp_unpack(64'(b_reg), EXP_W, MAN_W);
   assign unused_fields = ^{fa.exp[15:EXP_W], fa.frac[63:MAN_W],
                            fb.exp[15:EXP_W], fb.frac[63:MAN_W]};

   // Order operands by magnitude; zeros compare as 0 whatever their fraction.
   always_comb begin
      ea      = fa.exp[EXP_W-1:0];
      eb      = fb.exp[EXP_W-1:0];
      fra     = fa.frac[MAN_W-1:0];
      frb     = fb.frac[MAN_W-1:0];
      sa      = fa.sign;
      sb_eff  = fb.sign ^ sub_reg;
      sat_a   = &ea;
      sat_b   = &eb;
      mag_a   = (ea == '0) ? '0 : {ea, fra};
      mag_b   = (eb == '0) ? '0 : {eb, frb};
      swap    = mag_b > mag_a;
      sx      = swap ? sb_eff : sa;
      sy      = swap ? sa : sb_eff;
      ex      = swap ? eb : ea;
      ey      = swap ? ea : eb;
      frx     = swap ? frb : fra;
      fry     = swap ? fra : frb;
      k_align = int'(ex) - int'(ey);
      if (k_align > KMAX)
         k_align = KMAX;
   end

   assign x_ext = {1'b0, x_reg, 3'b000};
   assign y_ext = {1'b0, y_reg};
   assign sum   = eff_sub_reg ? (x_ext - y_ext) : (x_ext + y_ext);

   fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .sign   (sign_reg),
      .exp_in (exp_reg),
      .mant   (w_reg[MAN_W+3:3]),
      .grs    (w_reg[2:0]),
      .result (rp_result),
      .status (rp_status)
   );

   always_comb begin
      state_next      = state_reg;
      a_next          = a_reg;
      b_next          = b_reg;
      sub_next        = sub_reg;
      sign_next       = sign_reg;
      eff_sub_next    = eff_sub_reg;
      exp_next        = exp_reg;
      x_next          = x_reg;
      y_next          = y_reg;
      w_next          = w_reg;
      cnt_next        = cnt_reg;
      bypass_next     = bypass_reg;
      res_data_next   = res_data_reg;
      res_status_next = res_status_reg;
      data_next       = data_reg;
      status_next     = status_reg;
      busy            = (state_reg != S_IDLE);
      done            = (state_reg == S_DONE);
      case (state_reg)
         S_IDLE: if (start) begin
            a_next     = Op_A_in;
            b_next     = Op_B_in;
            sub_next   = op_sub;
            state_next = S_COMPARE;
         end
         S_COMPARE: begin
            sign_next       = sx;
            eff_sub_next    = sx ^ sy;
            exp_next        = signed'({2'b00, ex});
            x_next          = {1'b1, frx};
            y_next          = {1'b1, fry, 3'b000};
            cnt_next        = CW'(k_align);
            bypass_next     = 1'b1;
            res_data_next   = '0;
            res_status_next = '0;
            state_next      = S_ROUND;
            // Special and cancelled results ride through ROUND unchanged.
            if (sat_a | sat_b) begin
               res_data_next = {(sat_a & sat_b & (sa != sb_eff)) ? 1'b0 : (sat_a ? sa : sb_eff),
                                {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               res_status_next[ST_OVF] = 1'b1;
            end else if (ey == '0) begin
               if (ex == '0) begin
                  res_data_next[W-1]       = sa & sb_eff;
                  res_status_next[ST_ZERO] = 1'b1;
               end else begin
                  res_data_next = {sx, ex, frx};
               end
            end else begin
               bypass_next = 1'b0;
               state_next  = (k_align == 0) ? S_ADD : S_ALIGN;
            end
         end
         S_ALIGN: begin
            y_next   = {1'b0, y_reg[MAN_W+3:2], y_reg[1] | y_reg[0]};
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1))
               state_next = S_ADD;
         end
         S_ADD: begin
            w_next = sum;
            if (sum == '0) begin
               bypass_next              = 1'b1;
               res_data_next            = '0;
               res_status_next          = '0;
               res_status_next[ST_ZERO] = 1'b1;
               state_next               = S_ROUND;
            end else if (sum[MAN_W+4] || !sum[MAN_W+3]) begin
               state_next = S_NORM;
            end else begin
               state_next = S_ROUND;
            end
         end
         S_NORM: begin
            if (w_reg[MAN_W+4]) begin
               w_next     = {1'b0, w_reg[MAN_W+4:2], w_reg[1] | w_reg[0]};
               exp_next   = exp_reg + E_ONE;
               state_next = S_ROUND;
            end else begin
               w_next   = {w_reg[MAN_W+3:0], w_reg[0]};
               exp_next = exp_reg - E_ONE;
               if (w_reg[MAN_W+2])
                  state_next = S_ROUND;
            end
         end
         S_ROUND: begin
            data_next   = bypass_reg ? res_data_reg : rp_result;
            status_next = bypass_reg ? res_status_reg : rp_status;
            state_next  = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_100kHz or posedge reset) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         a_reg          <= '0;
         b_reg          <= '0;
         sub_reg        <= 1'b0;
         sign_reg       <= 1'b0;
         eff_sub_reg    <= 1'b0;
         exp_reg        <= '0;
         x_reg          <= '0;
         y_reg          <= '0;
         w_reg          <= '0;
         cnt_reg        <= '0;
         bypass_reg     <= 1'b0;
         res_data_reg   <= '0;
         res_status_reg <= '0;
         data_reg       <= '0;
         status_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         a_reg          <= a_next;
         b_reg          <= b_next;
         sub_reg        <= sub_next;
         sign_reg       <= sign_next;
         eff_sub_reg    <= eff_sub_next;
         exp_reg        <= exp_next;
         x_reg          <= x_next;
         y_reg          <= y_next;
         w_reg          <= w_next;
         cnt_reg        <= cnt_next;
         bypass_reg     <= bypass_next;
         res_data_reg   <= res_data_next;
         res_status_reg <= res_status_next;
         data_reg       <= data_next;
         status_reg     <= status_next;
      end
   end

   assign data_out   = data_reg;
   assign status_out = status_reg;

endmodule

// File: tb/tb_fp_addsub_param.sv
// Bench for fp_addsub_param at the default 6/25 format: vector table through a
// scoreboard queue, plus hand sequences for ignored start and mid-op reset.
`timescale 1ns/1ps
module tb_fp_addsub_param;
   logic        clock_100kHz = 1'b0;
   logic        reset;
   logic        start;
   logic        op_sub;
   logic [31:0] Op_A_in;
   logic [31:0] Op_B_in;
   logic        busy;
   logic        done;
   logic [31:0] data_out;
   logic [3:0]  status_out;

   fp_addsub_param #(.EXP_W(6), .MAN_W(25)) dut (
      .clock_100kHz (clock_100kHz),
      .reset        (reset),
      .start        (start),
      .op_sub       (op_sub),
      .Op_A_in      (Op_A_in),
      .Op_B_in      (Op_B_in),
      .busy         (busy),
      .done         (done),
      .data_out     (data_out),
      .status_out   (status_out)
   );

   always #5000 clock_100kHz = ~clock_100kHz;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] data;
      logic [3:0]  status;
      int          lat;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic add_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] data, input logic [3:0] status,
                          input int lat);
      vec_t v;
      v.name = name; v.a = a; v.b = b; v.sub = sub;
      v.data = data; v.status = status; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Called at a negedge; inject >= 0 pulses start with other operands mid-op.
   task automatic run_op(input vec_t v, input int inject);
      vec_t e;
      int   lat;
      bit   got, busy_ok;
      sb.push_back(v);
      Op_A_in = v.a; Op_B_in = v.b; op_sub = v.sub; start = 1'b1;
      @(negedge clock_100kHz);
      start = 1'b0;
      lat = 0; got = 1'b0; busy_ok = 1'b1;
      while (!got && lat < 200) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (lat == inject) begin
            start = 1'b1; Op_A_in = 32'h7E000000; Op_B_in = 32'h3E000000; op_sub = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clock_100kHz);
         lat++;
         got = (done === 1'b1);
      end
      start = 1'b0;
      e = sb.pop_front();
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done within %0d cycles, expected %0d", e.name, lat, e.lat);
      end else begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         check({e.name, " latency"}, 32'(lat), 32'(e.lat));
         check({e.name, " data"}, data_out, e.data);
         check({e.name, " status"}, {28'd0, status_out}, {28'd0, e.status});
         check({e.name, " busy"}, {31'd0, busy_ok}, 32'd1);
         $display("op %-12s a=%h b=%h sub=%0d -> data=%h status=%b latency=%0d",
                  e.name, e.a, e.b, e.sub, data_out, status_out, lat);
         @(negedge clock_100kHz);
         check({e.name, " idle after done"}, {30'd0, done, busy}, 32'd0);
      end
   endtask

   initial begin
      #100_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_done;
      reset = 1'b1; start = 1'b0; op_sub = 1'b0; Op_A_in = '0; Op_B_in = '0;
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset data", data_out, 32'd0);
      check("reset status", {28'd0, status_out}, 32'd0);

      add_vec("1+2",         32'h3E000000, 32'h40000000, 1'b0, 32'h41000000, 4'b0000, 4);
      add_vec("3-2",         32'h41000000, 32'h40000000, 1'b1, 32'h3E000000, 4'b0000, 4);
      add_vec("1-1",         32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001, 3);
      add_vec("ovf",         32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b1010, 4);
      add_vec("tiny",        32'h3E000000, 32'h02000000, 1'b0, 32'h3E000000, 4'b1000, 31);
      add_vec("zeroB",       32'h3E000000, 32'h00000001, 1'b0, 32'h3E000000, 4'b0000, 2);
      add_vec("sat+1",       32'h7E000000, 32'h3E000000, 1'b0, 32'h7E000000, 4'b0010, 2);
      add_vec("sat-sat",     32'h7E000000, 32'h7E000000, 1'b1, 32'h7E000000, 4'b0010, 2);
      add_vec("-sat+1",      32'hFE000000, 32'h3E000000, 1'b0, 32'hFE000000, 4'b0010, 2);
      add_vec("-0+-0",       32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001, 2);
      add_vec("-0--0",       32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 4'b0001, 2);
      add_vec("2-3",         32'h40000000, 32'h41000000, 1'b1, 32'hBE000000, 4'b0000, 4);
      add_vec("1+1",         32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0000, 4);
      add_vec("-1+-2",       32'hBE000000, 32'hC0000000, 1'b0, 32'hC1000000, 4'b0000, 4);
      add_vec("lsb",         32'h3E000000, 32'h0C000000, 1'b0, 32'h3E000001, 4'b0000, 28);
      add_vec("tie even",    32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b1000, 29);
      add_vec("tie up",      32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b1000, 29);
      add_vec("above half",  32'h3E000000, 32'h0B000000, 1'b0, 32'h3E000001, 4'b1000, 29);
      add_vec("round carry", 32'h3FFFFFFF, 32'h0A000000, 1'b0, 32'h40000000, 4'b1000, 29);
      add_vec("unf",         32'h03000000, 32'h02000000, 1'b1, 32'h00000000, 4'b1101, 4);

      repeat (2) @(negedge clock_100kHz);
      reset = 1'b0;

      foreach (vecs[i]) run_op(vecs[i], -1);

      // Second start during ALIGN of 1.0+2.0 must not disturb the result.
      vecs[0].name = "1+2 ignore";
      run_op(vecs[0], 1);

      // Reset in the middle of a long ALIGN run.
      Op_A_in = 32'h3E000000; Op_B_in = 32'h02000000; op_sub = 1'b0; start = 1'b1;
      @(negedge clock_100kHz);
      start = 1'b0;
      repeat (5) @(negedge clock_100kHz);
      check("busy before reset", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("midop reset busy", {31'd0, busy}, 32'd0);
      check("midop reset done", {31'd0, done}, 32'd0);
      check("midop reset data", data_out, 32'd0);
      check("midop reset status", {28'd0, status_out}, 32'd0);
      @(negedge clock_100kHz);
      reset = 1'b0;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clock_100kHz);
         if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      end
      check("no done after reset", {31'd0, seen_done}, 32'd0);
      $display("op reset-abort  a=3e000000 b=02000000 sub=0 -> aborted, outputs cleared");

      vecs[0].name = "1+2 after rst";
      run_op(vecs[0], -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
